// File: rtl/spi_config_regs_if.sv
// SPI pin bundle between an external controller and the configuration register file.
// All three signals are asynchronous to the register file's clock.
interface spi_config_regs_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (
    output sclk,
    output copi,
    output ncs
  );

  modport slave (
    input sclk,
    input copi,
    input ncs
  );
endinterface

// File: rtl/spi_config_regs.sv
// SPI-slave register file driving the PWM peripheral's enable and duty-cycle inputs.
// Receives 16-bit write frames (R/W, 7-bit address, 8-bit data, MSB first) in SPI mode 0.
// The pins are synchronised into the clk domain and edge-detected there; a frame commits on the
// chip-select rising edge only if exactly 16 bits arrived, it is a write, and the address exists.
module spi_config_regs #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_config_regs_if.slave     spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFull,
    StOver
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;

  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_rise;
  logic                   ncs_fall;

  state_e                 state_q;
  logic [4:0]             bit_cnt_q;
  logic [15:0]            shift_q;
  logic                   addr_valid;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  assign addr_valid = (32'(shift_q[14:8]) < NUM_REGS);

  // Synchronise the pins; copi gets the same depth as sclk so the sampled bit lines up with the
  // detected sclk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  // Frame FSM, bit counter, shift register and the committed configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (ncs_rise) begin
      if (state_q == StFull && shift_q[15] && addr_valid) begin
        case (shift_q[14:8])
          7'd0:    en_reg_out_7_0  <= shift_q[7:0];
          7'd1:    en_reg_out_15_8 <= shift_q[7:0];
          7'd2:    en_reg_pwm_7_0  <= shift_q[7:0];
          7'd3:    en_reg_pwm_15_8 <= shift_q[7:0];
          7'd4:    pwm_duty_cycle  <= shift_q[7:0];
          default: ;
        endcase
      end
      state_q <= StIdle;
    end else if (ncs_fall) begin
      state_q   <= StShift;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (sclk_rise && !ncs_s && state_q != StIdle) begin
      // Idle is excluded so a frame already in flight at reset release is ignored.
      if (bit_cnt_q < 5'd16) begin
        shift_q <= {shift_q[14:0], copi_s};
      end
      if (bit_cnt_q < 5'd17) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      case (state_q)
        StShift: if (bit_cnt_q == 5'd15) state_q <= StFull;
        StFull:  state_q <= StOver;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_config_regs.md
# spi_config_regs

SPI-slave register file that configures the PWM peripheral. It receives 16-bit write frames from an external SPI master over three general-purpose input pins. It decodes each frame into one of five 8-bit configuration registers, which drive the PWM peripheral's output-enable, PWM-enable and duty-cycle inputs directly. All SPI pins are asynchronous to `clk`; they are synchronised and edge-detected inside the block, so all logic runs in the single `clk` domain.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser; legal range ≥2.
- `NUM_REGS`, 5: number of implemented registers; addresses `0..NUM_REGS-1` are valid.

Ports:
- `clk`  in  1  system clock; the block's single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sclk`  in  1  SPI serial clock, mode 0 (idle low, data sampled on rising edge); asynchronous.
- `copi`  in  1  SPI controller-out/peripheral-in data, MSB first; asynchronous.
- `ncs`  in  1  SPI chip select, active-low; asynchronous.
- `en_reg_out_7_0`  out  8  register 0x00: output enable for PWM outputs 7..0.
- `en_reg_out_15_8`  out  8  register 0x01: output enable for PWM outputs 15..8.
- `en_reg_pwm_7_0`  out  8  register 0x02: PWM-mode enable for outputs 7..0.
- `en_reg_pwm_15_8`  out  8  register 0x03: PWM-mode enable for outputs 15..8.
- `pwm_duty_cycle`  out  8  register 0x04: shared duty cycle (0x00 = 0 %, 0xFF = 255/256).

## Operation
- **Synchronisation:** `sclk`, `copi` and `ncs` each pass through a `SYNC_STAGES`-deep synchroniser. One extra flop on the synchronised `sclk` and `ncs` provides edge detection. All three paths have identical delay, so `copi` stays aligned with `sclk`.
- **Frame format:** 16 bits, MSB first.
  - bit 15: R/W (1 = write, 0 = read).
  - bits 14:8: 7-bit address.
  - bits 7:0: data.
- **Bit counter:** 5 bits, saturating at 17.
  - Cleared on a synchronised `ncs` falling edge.
  - Increments on each synchronised `sclk` rising edge while `ncs` is low.
  - `copi` is shifted into a 16-bit shift register on each counted edge, up to 16 bits.
- **State machine:**
  - IDLE: `ncs` high. Go to SHIFT on `ncs` fall.
  - SHIFT: count < 16. Go to FULL at count = 16.
  - FULL: count = 16. Go to OVER on a further `sclk` rise.
  - OVER: more than 16 bits received; the frame will be discarded.
  - Any state returns to IDLE on `ncs` rise.
- **Commit:** on the synchronised `ncs` rising edge, the addressed register is written with bits 7:0 only if all of these hold:
  - state is FULL;
  - bit 15 = 1;
  - address < `NUM_REGS`.
- **Discards:** all other frames leave every register unchanged. This covers reads, invalid addresses, short frames, long frames and `ncs` toggles with no `sclk` activity. No read-back path exists.
- **Outputs:** registered; they change only on a commit or on reset.
- **Reset:** `rst_n` low asynchronously clears all synchronisers, the counter, the shift register, the state (to IDLE) and all five outputs to 0x00. Asserting reset mid-frame aborts the frame with no commit. After release, a frame is accepted only after a fresh `ncs` falling edge.

## Timing
- **Commit latency:** let clk edge k be the first that samples `ncs` high at the pin. The register output updates on edge k+`SYNC_STAGES`, which is edge k+2 at the default.
- **SCLK rate:** `sclk` high and low phases must each be at least `SYNC_STAGES`+1 clk periods; faster `sclk` is unsupported. At 50 MHz `clk` with the default setting, this gives ≤ 8 MHz `sclk`.
- **COPI setup:** `copi` must be stable from 1 clk before to 1 clk after each `sclk` rise at the pins.
- **NCS framing:**
  - `ncs` fall must lead the first `sclk` rise by at least 2 clk periods.
  - `ncs` rise must trail the last `sclk` rise by at least 2 clk periods.
  - `ncs` high time between frames must be at least 2 clk periods.
- **Back-to-back frames:** supported; each commits independently.
- **Stability:** no output glitches; each output changes only at a clk edge.

## Test plan
- **Reset:** hold `rst_n` low 5 clk, release. All five outputs = 0x00; `ncs` toggles with no `sclk` leave them 0x00.
- **Single writes:** send frame 0x80F0, then 0x84_80. Expect `en_reg_out_7_0` = 0xF0, then `pwm_duty_cycle` = 0x80, each exactly `SYNC_STAGES` clk after `ncs` rises. All other outputs stay unchanged.
- **Rejected frames:** send read frame 0x00AA, then invalid-address frame 0x85AA and 0xFF55. No output changes.
- **Wrong-length frames:** send a 15-bit frame then a 17-bit frame, each carrying address 0x02 and data 0x3C. `en_reg_pwm_7_0` stays 0x00. A following correct 16-bit frame 0x823C sets it to 0x3C.
- **Reset mid-frame:** assert `rst_n` after 10 bits of frame 0x81FF. All outputs = 0x00. The remaining bits plus `ncs` rise after release cause no write.
- **Back-to-back at minimum spacing:** at minimum `sclk` half-period (3 clk) and minimum `ncs` high time, send frames 0x8011, 0x8122, 0x8233, 0x8344, 0x8455. All five registers read 0x11, 0x22, 0x33, 0x44, 0x55.
